// File: rtl/buff_writer_pkg.sv
// Shared constants and FSM encoding for the line-buffer write-back block.
// Defaults match the panel line (100 bytes) and its home address 0x800.
// Imported by buff_writer and its interface.
package buff_writer_pkg;
  localparam int          DEF_N_BYTES   = 100;
  localparam int          DEF_ADDR_W    = 13;
  localparam logic [12:0] DEF_START_LOC = 13'h800;
  localparam int          CNT_W         = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/buff_writer_if.sv
// Memory write-port bundle: address, byte data and write strobe.
// No handshake; the memory latches the bundle on the edge after mem_we=1.
// master = writer side, slave = memory side.
interface buff_writer_if #(
  parameter int ADDR_W = 13
);
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_we;

  modport master (output mem_addr, mem_data, mem_we);
  modport slave  (input  mem_addr, mem_data, mem_we);
endinterface

// File: rtl/D_FF_Reg.sv
// Generic N_BIT register with load enable and synchronous clear.
// Latency: one cycle from d to q when en=1.
// No backpressure; holds value while en=0.
module D_FF_Reg #(
  parameter int N_BIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_BIT-1:0] d,
  output logic [N_BIT-1:0] q
);

  // Clear on reset, otherwise capture d when enabled.
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/UDL_CNT.sv
// Up/down counter with synchronous parallel load (load wins over count).
// Latency: one cycle per step.
// No backpressure; holds value while en=0 and load=0.
module UDL_CNT #(
  parameter int N_BIT = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [N_BIT-1:0] din,
  output logic [N_BIT-1:0] q
);

  // Reset, load, or step by one in the selected direction.
  always_ff @(posedge clk) begin
    if (rst)       q <= '0;
    else if (load) q <= din;
    else if (en)   q <= up ? q + N_BIT'(1) : q - N_BIT'(1);
  end

endmodule

// File: rtl/buff_writer.sv
// Snapshots an N_BYTES line image on trg and writes it byte-by-byte to memory.
// Latency: first write the cycle after trg is accepted; done N_BYTES+1 cycles after.
// en=0 stalls the transfer (no write that cycle); trg outside IDLE is dropped.
module buff_writer
  import buff_writer_pkg::*;
#(
  parameter int                N_BYTES   = DEF_N_BYTES,
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] START_LOC = ADDR_W'(DEF_START_LOC)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 trg,
  input  logic [N_BYTES*8-1:0] data_in,
  buff_writer_if.master        mem,
  output logic                 busy,
  output logic                 done
);

  state_t               state, state_nxt;
  logic [N_BYTES*8-1:0] shadow;
  logic [CNT_W-1:0]     cnt;
  logic [7:0]           cur_byte;
  logic                 accept;
  logic                 cnt_en;
  logic                 last;

  assign accept = (state == IDLE) && trg && en;
  assign cnt_en = (state == WRITE) && en;
  assign last   = (cnt == CNT_W'(N_BYTES - 1));

  // Line image frozen at acceptance so later data_in changes cannot leak in.
  D_FF_Reg #(.N_BIT(N_BYTES*8)) u_shadow (
    .clk (clk),
    .rst (rst),
    .en  (accept),
    .d   (data_in),
    .q   (shadow)
  );

  // Byte index: zeroed on acceptance, advances once per enabled write.
  UDL_CNT #(.N_BIT(CNT_W)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (cnt_en),
    .up   (1'b1),
    .load (accept),
    .din  ('0),
    .q    (cnt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: stay in WRITE until the last byte has been written.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WRITE;
      WRITE:   if (en && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Select shadow byte cnt; comparing against every index keeps widths exact.
  always_comb begin
    cur_byte = '0;
    for (int i = 0; i < N_BYTES; i++) begin
      if (cnt == CNT_W'(i)) cur_byte = shadow[8*i +: 8];
    end
  end

  // Write port and status; address/data are forced to zero when not writing.
  always_comb begin
    mem.mem_we   = cnt_en;
    mem.mem_addr = '0;
    mem.mem_data = '0;
    busy         = (state != IDLE);
    done         = (state == DONE);
    if (cnt_en) begin
      mem.mem_addr = START_LOC + ADDR_W'(cnt);
      mem.mem_data = cur_byte;
    end
  end

endmodule

// File: tb/tb_buff_writer.sv
// Directed bench for buff_writer: reset, full transfer, stall, snapshot,
// mid-transfer reset and back-to-back triggers, all against hand-built images.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_buff_writer;
  localparam int NB = 100;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            trg;
  logic [NB*8-1:0] data_in;
  logic            busy;
  logic            done;
  logic [NB*8-1:0] img_a;
  logic [NB*8-1:0] img_b;

  int errs   = 0;
  int checks = 0;

  buff_writer_if #(.ADDR_W(13)) mif ();

  buff_writer #(
    .N_BYTES   (NB),
    .ADDR_W    (13),
    .START_LOC (13'h800)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .trg     (trg),
    .data_in (data_in),
    .mem     (mif),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called at the falling edge of the IDLE cycle presenting trg=1/en=1.
  task automatic do_transfer(input logic [NB*8-1:0] img, input int stall_at, input int stall_len,
                             input bit poke, input bit hold, input bit again);
    int idx    = 0;
    int stalls = 0;
    int ncyc   = 0;
    check("trig_busy", {31'd0, busy}, 32'd0);
    while (idx < NB && ncyc < 2*NB) begin
      cyc();
      ncyc++;
      trg = hold;
      if (idx == stall_at && stalls < stall_len) begin
        en = 1'b0;
        stalls++;
      end else begin
        en = 1'b1;
      end
      if (poke && idx == 10 && en) begin
        data_in = ~img;
        trg     = 1'b1;
      end
      @(negedge clk);
      if (en) begin
        check("wr_we",   {31'd0, mif.mem_we}, 32'd1);
        check("wr_addr", {19'd0, mif.mem_addr}, 32'h800 + idx);
        check("wr_data", {24'd0, mif.mem_data}, {24'd0, img[8*idx +: 8]});
        check("wr_busy", {30'd0, busy, done}, 32'd2);
        idx++;
      end else begin
        check("stall_out", {18'd0, mif.mem_we, mif.mem_addr}, 32'd0);
        check("stall_data", {24'd0, mif.mem_data}, 32'd0);
        check("stall_busy", {31'd0, busy}, 32'd1);
      end
    end
    check("write_cycles", ncyc, NB + stall_len);
    cyc();
    en  = 1'b1;
    trg = hold;
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd1);
    check("done_busy",  {31'd0, busy}, 32'd1);
    check("done_we",    {31'd0, mif.mem_we}, 32'd0);
    cyc();
    trg = again;
    @(negedge clk);
    check("post_done", {31'd0, done}, 32'd0);
    check("post_busy", {31'd0, busy}, 32'd0);
    check("post_we",   {31'd0, mif.mem_we}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NB; i++) begin
      img_a[8*i +: 8] = 8'(i + 1);
      img_b[8*i +: 8] = 8'((i * 7 + 3) ^ 8'h5A);
    end
    rst = 1'b1; en = 1'b0; trg = 1'b0; data_in = '0;

    // Reset for two edges, then ten quiet cycles.
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) cyc();
      trg = 1'b0;
      en  = 1'b1;
      @(negedge clk);
      check("idle_out", {9'd0, mif.mem_we, mif.mem_addr, mif.mem_data, busy, done}, 32'd0);
    end

    // Full transfer of bytes 0x01..0x64.
    cyc();
    data_in = img_a; trg = 1'b1; en = 1'b1;
    @(negedge clk);
    do_transfer(img_a, -1, 0, 1'b0, 1'b0, 1'b0);

    // Three-cycle stall at index 50.
    cyc();
    data_in = img_b; trg = 1'b1; en = 1'b1;
    @(negedge clk);
    do_transfer(img_b, 50, 3, 1'b0, 1'b0, 1'b0);

    // Snapshot: data_in flipped and trg pulsed mid-transfer.
    cyc();
    data_in = img_a; trg = 1'b1; en = 1'b1;
    @(negedge clk);
    do_transfer(img_a, -1, 0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      @(negedge clk);
      check("no_requeue", {30'd0, busy, mif.mem_we}, 32'd0);
    end

    // trg ignored while en=0 in IDLE.
    cyc();
    data_in = img_b; trg = 1'b1; en = 1'b0;
    cyc();
    trg = 1'b0; en = 1'b1;
    @(negedge clk);
    check("trg_en0_ignored", {31'd0, busy}, 32'd0);

    // Mid-transfer reset at index 20.
    cyc();
    data_in = img_a; trg = 1'b1; en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      cyc();
      trg = 1'b0;
      @(negedge clk);
      check("pre_rst_addr", {19'd0, mif.mem_addr}, 32'h800 + k);
    end
    cyc();
    rst = 1'b1;
    @(negedge clk);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out", {9'd0, mif.mem_we, mif.mem_addr, mif.mem_data, busy, done}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      @(negedge clk);
      check("rst_no_done", {29'd0, done, busy, mif.mem_we}, 32'd0);
    end
    cyc();
    data_in = img_b; trg = 1'b1; en = 1'b1;
    @(negedge clk);
    do_transfer(img_b, -1, 0, 1'b0, 1'b0, 1'b0);

    // Back-to-back with trg held high throughout.
    cyc();
    data_in = img_a; trg = 1'b1; en = 1'b1;
    @(negedge clk);
    do_transfer(img_a, -1, 0, 1'b0, 1'b1, 1'b1);
    do_transfer(img_a, -1, 0, 1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
